// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default frame geometry and the common count width
// used by the scan counter and the sync FSMs.
package vga_timing_pkg;

    localparam int CNT_W       = 10;
    localparam int H_TOTAL_DEF = 800;
    localparam int V_TOTAL_DEF = 525;

endpackage

// File: rtl/pixel_scan_counter_wrap.sv
// wrap_counter: modulo-MODULUS up-counter with enable, asynchronous reset and a
// combinational terminal-count flag (high while the count sits at MODULUS-1).
module wrap_counter
    import vga_timing_pkg::*;
#(
    parameter int MODULUS = H_TOTAL_DEF,
    parameter int W       = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == LAST);

endmodule

// File: rtl/pixel_scan_counter.sv
// Horizontal/vertical raster scan counter with line and frame end pulses.
// Define PIX_DIV2_EN to run the pixel rate at half the CLK rate.
module pixel_scan_counter
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             HOLD,
    output logic [CNT_W-1:0] HCOUNT,
    output logic [CNT_W-1:0] VCOUNT,
    output logic             PIX_EN,
    output logic             LINE_END,
    output logic             FRAME_END
);

    logic pix_en;
    logic advance;
    logic h_tc;
    logic v_tc;

`ifdef PIX_DIV2_EN
    // Phase keeps toggling through HOLD so the pixel cadence never slips.
    logic phase_q;
    logic phase_d;

    assign phase_d = ~phase_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign pix_en = phase_q;
`else
    assign pix_en = 1'b1;
`endif

    assign advance = pix_en & ~HOLD;

    wrap_counter #(
        .MODULUS (H_TOTAL),
        .W       (CNT_W)
    ) u_hcount (
        .clk_i   (CLK),
        .rst_i   (RST),
        .en_i    (advance),
        .count_o (HCOUNT),
        .tc_o    (h_tc)
    );

    wrap_counter #(
        .MODULUS (V_TOTAL),
        .W       (CNT_W)
    ) u_vcount (
        .clk_i   (CLK),
        .rst_i   (RST),
        .en_i    (advance & h_tc),
        .count_o (VCOUNT),
        .tc_o    (v_tc)
    );

    // Counts are zero during reset, so h_tc (and both pulses) stay low there.
    assign PIX_EN    = pix_en;
    assign LINE_END  = h_tc & advance;
    assign FRAME_END = h_tc & advance & v_tc;

endmodule

// File: tb/tb_pixel_scan_counter.sv
// Directed bench for pixel_scan_counter: a default-geometry instance and a small
// 10x4 instance share clock, reset and hold.
module tb_pixel_scan_counter;

`ifdef PIX_DIV2_EN
    localparam int CPA     = 2;
    localparam int RST_V   = 40;
    localparam logic RST_PE = 1'b0;
`else
    localparam int CPA     = 1;
    localparam int RST_V   = 100;
    localparam logic RST_PE = 1'b1;
`endif

    logic       CLK  = 1'b0;
    logic       RST  = 1'b1;
    logic       HOLD = 1'b0;

    logic [9:0] hcount, vcount;
    logic       pix_en, line_end, frame_end;
    logic [9:0] s_hcount, s_vcount;
    logic       s_pix_en, s_line_end, s_frame_end;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    pixel_scan_counter dut (
        .CLK       (CLK),
        .RST       (RST),
        .HOLD      (HOLD),
        .HCOUNT    (hcount),
        .VCOUNT    (vcount),
        .PIX_EN    (pix_en),
        .LINE_END  (line_end),
        .FRAME_END (frame_end)
    );

    pixel_scan_counter #(.H_TOTAL(10), .V_TOTAL(4)) dut_s (
        .CLK       (CLK),
        .RST       (RST),
        .HOLD      (HOLD),
        .HCOUNT    (s_hcount),
        .VCOUNT    (s_vcount),
        .PIX_EN    (s_pix_en),
        .LINE_END  (s_line_end),
        .FRAME_END (s_frame_end)
    );

    task automatic test_reset();
        RST  = 1'b1;
        HOLD = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        n_checks++; if (hcount !== 10'd0) begin n_fail++; $display("FAIL reset_hcount: got %0d expected 0", hcount); end
        n_checks++; if (vcount !== 10'd0) begin n_fail++; $display("FAIL reset_vcount: got %0d expected 0", vcount); end
        n_checks++; if (line_end !== 1'b0) begin n_fail++; $display("FAIL reset_line_end: got %b expected 0", line_end); end
        n_checks++; if (frame_end !== 1'b0) begin n_fail++; $display("FAIL reset_frame_end: got %b expected 0", frame_end); end
        n_checks++; if (pix_en !== RST_PE) begin n_fail++; $display("FAIL reset_pix_en: got %b expected %b", pix_en, RST_PE); end
        n_checks++; if (s_hcount !== 10'd0 || s_vcount !== 10'd0) begin n_fail++; $display("FAIL reset_small: got %0d/%0d expected 0/0", s_hcount, s_vcount); end
        RST = 1'b0;
        $display("test_reset done");
    endtask

    // One full line from reset release: HCOUNT steps 0..799 then wraps, VCOUNT 0->1.
    task automatic test_line();
        int   h, v;
        logic pe, le;
        for (int k = 0; k <= CPA * 800; k++) begin
            h  = (k / CPA) % 800;
            v  = (k / CPA) / 800;
            pe = (CPA == 1) ? 1'b1 : logic'(k % 2);
            le = (h == 799) && pe;
            n_checks++; if (hcount !== 10'(h)) begin n_fail++; $display("FAIL line_hcount k=%0d: got %0d expected %0d", k, hcount, h); end
            n_checks++; if (vcount !== 10'(v)) begin n_fail++; $display("FAIL line_vcount k=%0d: got %0d expected %0d", k, vcount, v); end
            n_checks++; if (pix_en !== pe) begin n_fail++; $display("FAIL line_pix_en k=%0d: got %b expected %b", k, pix_en, pe); end
            n_checks++; if (line_end !== le) begin n_fail++; $display("FAIL line_line_end k=%0d: got %b expected %b", k, line_end, le); end
            n_checks++; if (frame_end !== 1'b0) begin n_fail++; $display("FAIL line_frame_end k=%0d: got %b expected 0", k, frame_end); end
            if (k < CPA * 800) @(negedge CLK);
        end
        $display("test_line done");
    endtask

    // Hold at the last pixel of line 1 for five clocks, then release.
    task automatic test_hold();
        repeat (CPA * 799) @(negedge CLK);
        n_checks++; if (hcount !== 10'd799 || vcount !== 10'd1) begin n_fail++; $display("FAIL hold_setup: got %0d/%0d expected 799/1", hcount, vcount); end
        HOLD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (hcount !== 10'd799 || vcount !== 10'd1) begin n_fail++; $display("FAIL hold_frozen i=%0d: got %0d/%0d expected 799/1", i, hcount, vcount); end
            n_checks++; if (line_end !== 1'b0 || frame_end !== 1'b0) begin n_fail++; $display("FAIL hold_pulses i=%0d: got %b%b expected 00", i, line_end, frame_end); end
            @(negedge CLK);
        end
        HOLD = 1'b0;
        #1;
        n_checks++; if (line_end !== 1'b1) begin n_fail++; $display("FAIL hold_release_line_end: got %b expected 1", line_end); end
        @(negedge CLK);
        n_checks++; if (hcount !== 10'd0 || vcount !== 10'd2) begin n_fail++; $display("FAIL hold_resume: got %0d/%0d expected 0/2", hcount, vcount); end
        $display("test_hold done");
    endtask

    // Reset between clock edges mid-frame; outputs must clear before the next edge.
    task automatic test_async_reset();
        repeat (CPA * ((RST_V - 2) * 800 + 400)) @(negedge CLK);
        n_checks++; if (hcount !== 10'd400 || vcount !== 10'(RST_V)) begin n_fail++; $display("FAIL areset_setup: got %0d/%0d expected 400/%0d", hcount, vcount, RST_V); end
        #2 RST = 1'b1;
        #1;
        n_checks++; if (hcount !== 10'd0 || vcount !== 10'd0) begin n_fail++; $display("FAIL areset_immediate: got %0d/%0d expected 0/0", hcount, vcount); end
        n_checks++; if (s_hcount !== 10'd0 || s_vcount !== 10'd0) begin n_fail++; $display("FAIL areset_small: got %0d/%0d expected 0/0", s_hcount, s_vcount); end
        n_checks++; if (line_end !== 1'b0 || frame_end !== 1'b0) begin n_fail++; $display("FAIL areset_pulses: got %b%b expected 00", line_end, frame_end); end
        n_checks++; if (pix_en !== RST_PE) begin n_fail++; $display("FAIL areset_pix_en: got %b expected %b", pix_en, RST_PE); end
        @(negedge CLK);
        n_checks++; if (hcount !== 10'd0 || line_end !== 1'b0 || frame_end !== 1'b0) begin n_fail++; $display("FAIL areset_held: got h=%0d le=%b fe=%b expected 0,0,0", hcount, line_end, frame_end); end
        RST = 1'b0;
        $display("test_async_reset done");
    endtask

    // Small 10x4 instance: two full frames from reset release.
    task automatic test_frame_small();
        int   a, h, v, fe_count, le_count;
        logic pe, le, fe;
        fe_count = 0;
        le_count = 0;
        for (int k = 0; k <= CPA * 80; k++) begin
            a  = k / CPA;
            h  = a % 10;
            v  = (a / 10) % 4;
            pe = (CPA == 1) ? 1'b1 : logic'(k % 2);
            le = (h == 9) && pe;
            fe = le && (v == 3);
            if (s_frame_end === 1'b1) fe_count++;
            if (s_line_end === 1'b1) le_count++;
            n_checks++; if (s_hcount !== 10'(h) || s_vcount !== 10'(v)) begin n_fail++; $display("FAIL small_count k=%0d: got %0d/%0d expected %0d/%0d", k, s_hcount, s_vcount, h, v); end
            n_checks++; if (s_line_end !== le) begin n_fail++; $display("FAIL small_line_end k=%0d: got %b expected %b", k, s_line_end, le); end
            n_checks++; if (s_frame_end !== fe) begin n_fail++; $display("FAIL small_frame_end k=%0d: got %b expected %b", k, s_frame_end, fe); end
            if (k < CPA * 80) @(negedge CLK);
        end
        n_checks++; if (fe_count != 2) begin n_fail++; $display("FAIL small_frame_pulses: got %0d expected 2", fe_count); end
        n_checks++; if (le_count != 8) begin n_fail++; $display("FAIL small_line_pulses: got %0d expected 8", le_count); end
        $display("test_frame_small done");
    endtask

    initial begin
        test_reset();
        test_line();
        test_hold();
        test_async_reset();
        test_frame_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
